// File: rtl/l15_pkg.sv
// Shared encodings for the L1.5 memory responder: request/return types, sizes, FSM states.
// Also holds the byte-lane helpers used to build store enables.
package l15_pkg;

    typedef enum logic [4:0] {
        LOAD_RQ  = 5'b00000,
        STORE_RQ = 5'b00001
    } l15_rqtype_e;

    typedef enum logic [3:0] {
        LOAD_RET = 4'b0000,
        ST_ACK   = 4'b0100,
        ERR_RET  = 4'b1111
    } l15_rettype_e;

    typedef enum logic [2:0] {
        SZ_BYTE = 3'b000,
        SZ_HALF = 3'b001,
        SZ_WORD = 3'b010,
        SZ_DW   = 3'b011
    } l15_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } l15_state_e;

    // Byte offset within the doubleword after dropping bits below size alignment.
    function automatic logic [2:0] l15_align_off(input logic [2:0] size, input logic [2:0] lo);
        logic [2:0] off;
        case (size)
            SZ_BYTE: off = lo;
            SZ_HALF: off = {lo[2:1], 1'b0};
            SZ_WORD: off = {lo[2], 2'b00};
            default: off = 3'b000;
        endcase
        return off;
    endfunction

    function automatic logic [7:0] l15_byte_mask(input logic [2:0] size, input logic [2:0] lo);
        logic [2:0] a;
        logic [7:0] m;
        a = l15_align_off(size, lo);
        case (size)
            SZ_BYTE: m = 8'h01 << a;
            SZ_HALF: m = 8'h03 << a;
            SZ_WORD: m = 8'h0F << a;
            SZ_DW:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/l15_sram_bw.sv
// 64-bit backing store with per-byte write enables and a registered read port.
// Contents are deliberately not reset.
module l15_sram_bw #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [7:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem_q [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int k = 0; k < 8; k++) begin
                    if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/l15_mem_responder.sv
// Single-outstanding L1.5 memory responder: accepts one request, acks the header,
// performs the access after a fixed latency and holds the response until consumed.
//
// state  | meaning
// IDLE   | waiting for mem_l15_val; request fields latched on acceptance
// HDR    | header_ack/ack high for this one cycle; latency counter loaded
// ACCESS | counting down; memory read or byte-masked write in the last cycle
// RESP   | response held stable until mem_l15_req_ack is sampled
module l15_mem_responder
    import l15_pkg::*;
#(
    parameter int DEPTH_DW = 1024,
    parameter int ACC_LAT  = 2
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        mem_l15_val,
    input  logic [4:0]  mem_l15_rqtype,
    input  logic [2:0]  mem_l15_size,
    input  logic [31:0] mem_l15_address,
    input  logic [63:0] mem_l15_data,
    input  logic        mem_l15_req_ack,
    output logic        l15_mem_header_ack,
    output logic        l15_mem_ack,
    output logic        l15_mem_val,
    output logic [3:0]  l15_mem_returntype,
    output logic [63:0] l15_mem_data_0,
    output logic [63:0] l15_mem_data_1
);

    localparam int IW = $clog2(DEPTH_DW);
    localparam int CW = $clog2(ACC_LAT + 3);

    l15_state_e    state_q;
    logic [4:0]    rqtype_q;
    logic [2:0]    size_q;
    logic [IW+2:0] addr_q;
    logic [63:0]   data_q;
    logic [CW-1:0] cnt_q;
    logic          hdr_ack_q;
    logic          val_q;
    logic [3:0]    rtype_q;
    logic          resp_load_q;

    logic          is_load;
    logic          is_store;
    logic          req_err;
    logic          last_access;
    logic [2:0]    off;
    logic          sram_en;
    logic [63:0]   sram_rdata;
    logic          unused_addr_hi;

    assign unused_addr_hi = ^mem_l15_address[31:IW+3];

    assign is_load  = (rqtype_q == LOAD_RQ);
    assign is_store = (rqtype_q == STORE_RQ);
    assign req_err  = !(is_load || is_store) || (size_q > SZ_DW);
    assign off      = l15_align_off(size_q, addr_q[2:0]);

    // Counter holds ACC_LAT on ACCESS entry; the cycle where it would step to 1
    // is the final ACCESS cycle, giving ACC_LAT+1 cycles from request to response.
    assign last_access = (cnt_q <= CW'(2));
    assign sram_en     = (state_q == ACCESS) && last_access && !req_err;

    l15_sram_bw #(
        .DEPTH (DEPTH_DW),
        .AW    (IW)
    ) u_sram (
        .clk     (clk),
        .en_i    (sram_en),
        .we_i    (is_store),
        .be_i    (l15_byte_mask(size_q, addr_q[2:0])),
        .addr_i  (addr_q[IW+2:3]),
        .wdata_i (data_q << {off, 3'b000}),
        .rdata_o (sram_rdata)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            rqtype_q    <= '0;
            size_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            hdr_ack_q   <= 1'b0;
            val_q       <= 1'b0;
            rtype_q     <= '0;
            resp_load_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_l15_val) begin
                        rqtype_q  <= mem_l15_rqtype;
                        size_q    <= mem_l15_size;
                        addr_q    <= mem_l15_address[IW+2:0];
                        data_q    <= mem_l15_data;
                        hdr_ack_q <= 1'b1;
                        state_q   <= HDR;
                    end
                end
                HDR: begin
                    hdr_ack_q <= 1'b0;
                    cnt_q     <= CW'(ACC_LAT);
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    cnt_q <= cnt_q - CW'(1);
                    if (last_access) begin
                        val_q       <= 1'b1;
                        rtype_q     <= req_err ? ERR_RET : (is_store ? ST_ACK : LOAD_RET);
                        resp_load_q <= is_load && !req_err;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (mem_l15_req_ack) begin
                        val_q       <= 1'b0;
                        rtype_q     <= '0;
                        resp_load_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The read register only updates on a load access, so it is stable throughout RESP.
    assign l15_mem_header_ack = hdr_ack_q;
    assign l15_mem_ack        = hdr_ack_q;
    assign l15_mem_val        = val_q;
    assign l15_mem_returntype = rtype_q;
    assign l15_mem_data_0     = resp_load_q ? sram_rdata : 64'd0;
    assign l15_mem_data_1     = 64'd0;

endmodule

// File: doc/l15_mem_responder.md
L15_MEM_RESPONDER -- requirements
Module: l15_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_DW, default 1024: backing-store depth in 64-bit doublewords, a power of two.
REQ-002 SHALL have parameter ACC_LAT, default 2: access latency in cycles, minimum 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_l15_val, input, 1 bit: request valid.
REQ-006 SHALL have port mem_l15_rqtype, input, 5 bits: request type; 5'b00000 = LOAD_RQ, 5'b00001 = STORE_RQ.
REQ-007 SHALL have port mem_l15_size, input, 3 bits: access size; 000 = byte, 001 = half, 010 = word, 011 = doubleword.
REQ-008 SHALL have port mem_l15_address, input, 32 bits: byte address.
REQ-009 SHALL have port mem_l15_data, input, 64 bits: store data, LSB-justified.
REQ-010 SHALL have port mem_l15_req_ack, input, 1 bit: requester has consumed the response.
REQ-011 SHALL have port l15_mem_header_ack, output, 1 bit: request accepted, one-cycle pulse.
REQ-012 SHALL have port l15_mem_ack, output, 1 bit: same as header_ack, asserted in the same cycle.
REQ-013 SHALL have port l15_mem_val, output, 1 bit: response valid.
REQ-014 SHALL have port l15_mem_returntype, output, 4 bits: 4'b0000 = LOAD_RET, 4'b0100 = ST_ACK, 4'b1111 = ERR_RET.
REQ-015 SHALL have port l15_mem_data_0, output, 64 bits: load data, the full aligned doubleword.
REQ-016 SHALL have port l15_mem_data_1, output, 64 bits: always zero.

Function
REQ-017 SHALL implement FSM states IDLE, HDR, ACCESS, RESP, all registered.
REQ-018 In IDLE with mem_l15_val=1, SHALL latch rqtype, size, address and data, and go to HDR.
REQ-019 In HDR, SHALL assert header_ack and ack for exactly one cycle, load the latency counter with ACC_LAT, and go to ACCESS.
REQ-020 In ACCESS, SHALL decrement the counter each cycle and go to RESP when it reaches 1, so response valid rises ACC_LAT+1 cycles after the request is sampled.
REQ-021 A STORE_RQ SHALL commit to memory in the last ACCESS cycle and write only the byte lanes selected by size and address[2:0].
REQ-022 Store data lane k SHALL come from mem_l15_data[8*(k-a)+7 : 8*(k-a)], where a is address[2:0] masked to size alignment.
REQ-023 Address bits [2:0] below size alignment SHALL be ignored (forced alignment); size values above 3 SHALL produce ERR_RET.
REQ-024 The doubleword index SHALL be address[log2(DEPTH_DW)+2:3]; higher address bits SHALL be ignored, so addresses wrap.
REQ-025 A LOAD_RQ SHALL sample the doubleword in the last ACCESS cycle and present it on data_0 with LOAD_RET.
REQ-026 An unknown rqtype SHALL still be header-acked, SHALL cause no memory write, and SHALL return ERR_RET with data_0=0.
REQ-027 In RESP, SHALL hold l15_mem_val, returntype and data_0 stable until mem_l15_req_ack=1 is sampled, then go to IDLE.
REQ-028 mem_l15_val outside IDLE SHALL be ignored; no queueing, one outstanding request.
REQ-029 If mem_l15_val is still high in the IDLE cycle after RESP, SHALL treat it as a new request.
REQ-030 mem_l15_req_ack outside RESP SHALL be ignored.
REQ-031 Store data for ST_ACK SHALL be returned as data_0=0.

Reset
REQ-032 On nrst low, SHALL go to IDLE immediately and force header_ack, ack, l15_mem_val = 0, returntype = 0 and data_0 = 0.
REQ-033 Reset mid-operation SHALL abort the request; a store not yet committed SHALL not be written.
REQ-034 Memory contents SHALL not be reset.

Structure
REQ-035 Rqtype, returntype and size encodings and the FSM state enum SHALL live in the shared package l15_pkg.
REQ-036 The backing store SHALL be a sub-module l15_sram_bw: 64-bit wide, byte-write enables, synchronous read.

Verification
REQ-037 Store a word, then load it: STORE size=010, address 0x104, data 0xDEADBEEF, then LOAD size=011, address 0x100 -> data_0 = 0xDEADBEEF_00000000 (other lanes at prior value 0), LOAD_RET.
REQ-038 Latency: with ACC_LAT=2, val sampled at cycle 0 -> header_ack at cycle 1, l15_mem_val at cycle 3.
REQ-039 Held response: hold req_ack low for 5 cycles -> response held stable; it clears 1 cycle after req_ack=1.
REQ-040 Byte store: STORE size=000, address 0x7, data 0xAB -> only byte 7 changes; a following load of 0x0 returns 0xAB in bits [63:56].
REQ-041 Unknown request: rqtype 5'b00111 -> ERR_RET, data_0=0, memory unchanged.
REQ-042 Reset in the first ACCESS cycle of a store to 0x20 -> no write, outputs zero; a later load of 0x20 returns the old value.
